// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receiver.
// Holds the 2-bit symbol encodings that the classifier produces and the
// decoder consumes, and the classifier's FSM state type.
package morse_pkg;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_IDLE = 2'b00;
  localparam sym_t SYM_DOT  = 2'b01;
  localparam sym_t SYM_DASH = 2'b11;
  localparam sym_t SYM_LEND = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    LWAIT = 2'd3
  } state_e;

endpackage

// File: rtl/morse_debounce.sv
// Key line conditioning for the Morse classifier.
// Brings the asynchronous key into the clk domain, accepts a new level only
// after it has held for DEBOUNCE_CYC consecutive cycles, and produces
// single-cycle edge pulses of the accepted level.
// Ports:
//   clk    - system clock
//   rst    - synchronous reset, active-high
//   key_in - raw key, asynchronous, 1 = pressed
//   key_db - debounced key level
//   rise   - one-cycle pulse after key_db goes 0->1
//   fall   - one-cycle pulse after key_db goes 1->0
module morse_debounce #(
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_db,
  output logic rise,
  output logic fall
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYC - 1);

  logic          sync1_q;
  logic          key_s_q;
  logic          key_db_q;
  logic          key_db_dly_q;
  logic [DW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others; blocking here would collapse
  // the two synchroniser stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      key_s_q      <= 1'b0;
      key_db_q     <= 1'b0;
      key_db_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // Two-flop synchroniser: sync1_q may go metastable, key_s_q is clean.
      sync1_q      <= key_in;
      key_s_q      <= sync1_q;
      key_db_dly_q <= key_db_q;
      if (key_s_q == key_db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // This edge is the DEBOUNCE_CYC-th consecutive disagreement.
        key_db_q <= key_s_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign key_db = key_db_q;
  assign rise   = key_db_q & ~key_db_dly_q;
  assign fall   = ~key_db_q & key_db_dly_q;

endmodule

// File: rtl/morse_symbol_classifier.sv
// Morse receiver front end: times debounced key-down (mark) and key-up
// (space) intervals in units of TICK_DIV clk cycles and emits one classified
// symbol per event, plus a separate end-of-word strobe.
// Ports:
//   clk       - system clock
//   rst       - synchronous reset, active-high
//   key_in    - raw key, asynchronous, 1 = pressed
//   sym_code  - 00 idle, 01 dot, 11 dash, 10 letter-end (non-zero only with sym_valid)
//   sym_valid - one-cycle strobe qualifying sym_code
//   word_end  - one-cycle strobe at end of word
//   key_db    - debounced key level
//   busy      - high whenever the FSM is not IDLE
module morse_symbol_classifier
  import morse_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 8,
  parameter int DOT_MAX      = 30,
  parameter int LETTER_GAP   = 30,
  parameter int WORD_GAP     = 70,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [1:0] sym_code,
  output logic       sym_valid,
  output logic       word_end,
  output logic       key_db,
  output logic       busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] DOT_MAX_C  = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] LGAP_C     = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WGAP_C     = CNT_W'(WORD_GAP);

  logic rise;
  logic fall;
  logic key_edge;

  morse_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_in),
    .key_db (key_db),
    .rise   (rise),
    .fall   (fall)
  );

  assign key_edge = rise | fall;

  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             tick;
  logic             letter_hit;
  logic             word_hit;

  // NOTE: every signal assigned in this block gets a value on every path,
  // so no latch can be inferred.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    // Both timers restart on any key edge so intervals are measured from it.
    presc_d = (key_edge || tick) ? '0 : presc_q + 1'b1;
    cnt_d   = key_edge ? '0 : (tick ? cnt_inc : cnt_q);
    // Gap thresholds fire on the cycle whose tick makes the count reach them.
    letter_hit = tick && (cnt_inc == LGAP_C);
    word_hit   = tick && (cnt_inc == WGAP_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  state_e state_q;
  sym_t   sym_code_q;
  logic   sym_valid_q;
  logic   word_end_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sym_code_q  <= SYM_IDLE;
      sym_valid_q <= 1'b0;
      word_end_q  <= 1'b0;
    end else begin
      // Strobes last exactly one cycle unless re-asserted below.
      sym_code_q  <= SYM_IDLE;
      sym_valid_q <= 1'b0;
      word_end_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise) state_q <= MARK;
        end
        MARK: begin
          // cnt_q is the pre-edge count; a tick on this cycle is not added.
          if (fall) begin
            state_q     <= SPACE;
            sym_valid_q <= 1'b1;
            sym_code_q  <= (cnt_q < DOT_MAX_C) ? SYM_DOT : SYM_DASH;
          end
        end
        SPACE: begin
          // A new press beats a simultaneous letter-gap threshold.
          if (rise) begin
            state_q <= MARK;
          end else if (letter_hit) begin
            state_q     <= LWAIT;
            sym_valid_q <= 1'b1;
            sym_code_q  <= SYM_LEND;
          end
        end
        LWAIT: begin
          // Count keeps running from the fall, so WORD_GAP spans the whole space.
          if (rise) begin
            state_q <= MARK;
          end else if (word_hit) begin
            state_q    <= IDLE;
            word_end_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sym_code  = sym_code_q;
  assign sym_valid = sym_valid_q;
  assign word_end  = word_end_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// Self-checking bench for morse_symbol_classifier with small timing
// parameters. Stimulus is a list of key_in segments (level, length in
// cycles). The reference model derives expected events from those segments
// arithmetically: accepted key levels, mark lengths in ticks, gap thresholds.
module tb_morse_symbol_classifier;

  localparam int TD = 2;   // TICK_DIV
  localparam int DB = 3;   // DEBOUNCE_CYC
  localparam int DM = 4;   // DOT_MAX
  localparam int LG = 6;   // LETTER_GAP
  localparam int WG = 14;  // WORD_GAP
  localparam int CW = 16;  // CNT_W

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_in = 1'b0;
  logic [1:0] sym_code;
  logic       sym_valid;
  logic       word_end;
  logic       key_db;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit lvl;
    int len;
  } seg_t;

  typedef struct {
    int  cyc;
    int  ord;
    byte k;
  } ev_t;

  seg_t  segs[$];
  ev_t   exp_q[$];
  string obs_all;
  string obs_sym;
  int    first_k;
  int    viol;

  morse_symbol_classifier #(
    .TICK_DIV     (TD),
    .DEBOUNCE_CYC (DB),
    .DOT_MAX      (DM),
    .LETTER_GAP   (LG),
    .WORD_GAP     (WG),
    .CNT_W        (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .sym_code  (sym_code),
    .sym_valid (sym_valid),
    .word_end  (word_end),
    .key_db    (key_db),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic byte code_ch(input logic [1:0] c);
    case (c)
      2'b01:   return "D";
      2'b11:   return "H";
      2'b10:   return "L";
      default: return "?";
    endcase
  endfunction

  task automatic add_seg(input bit lvl, input int len);
    seg_t s;
    s.lvl = lvl;
    s.len = len;
    segs.push_back(s);
  endtask

  // Two-cycle reset with the key released; returns on the first observation
  // point after reset has been removed.
  task automatic do_reset();
    key_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives segs one cycle at a time and records what the DUT shows at each
  // observation point (negedge), relative to the start of the run.
  task automatic play();
    int r = 0;
    logic kp = 1'b0;
    logic bp = 1'b0;
    obs_all = "";
    obs_sym = "";
    first_k = -1;
    viol    = 0;
    foreach (segs[i]) begin
      for (int j = 0; j < segs[i].len; j++) begin
        if (key_db !== kp) begin
          obs_all = {obs_all, $sformatf("%c%0d ", (key_db === 1'b1) ? "K" : "k", r)};
          if (key_db === 1'b1 && first_k < 0) first_k = r;
          kp = key_db;
        end
        if (sym_valid === 1'b1) begin
          obs_all = {obs_all, $sformatf("%c%0d ", code_ch(sym_code), r)};
          obs_sym = {obs_sym, $sformatf("%0d ", sym_code)};
        end
        if (word_end === 1'b1) obs_all = {obs_all, $sformatf("W%0d ", r)};
        if (busy !== bp) begin
          obs_all = {obs_all, $sformatf("%c%0d ", (busy === 1'b1) ? "B" : "b", r)};
          bp = busy;
        end
        if ((sym_code !== 2'b00 && sym_valid !== 1'b1) ||
            (sym_valid === 1'b1 && (sym_code === 2'b00 || word_end === 1'b1)))
          viol++;
        key_in = segs[i].lvl;
        @(negedge clk);
        r++;
      end
    end
  endtask

  function automatic void put(input int total, input int cyc, input int ord, input byte k);
    ev_t e;
    int  pos;
    if (cyc >= total) return;
    e.cyc = cyc;
    e.ord = ord;
    e.k   = k;
    pos   = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc * 4 + exp_q[i].ord > cyc * 4 + ord) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, e);
  endfunction

  // Reference model. A segment at least DB cycles long with a new level is
  // accepted 2+DB cycles after it starts. A mark lasting d cycles of key_db
  // holds floor((d-1)/TD) whole ticks. A space strobes letter-end TD*LG+1
  // cycles after key_db falls and word-end TD*WG+1 cycles after it, unless
  // key_db has risen by the cycle before the strobe would appear.
  function automatic string predict();
    int    tq[$];
    bit    lq[$];
    int    t = 0;
    int    total;
    bit    acc = 1'b0;
    bit    busy_m = 1'b0;
    string s = "";
    exp_q.delete();
    foreach (segs[i]) begin
      if (segs[i].len >= DB && segs[i].lvl != acc) begin
        acc = segs[i].lvl;
        tq.push_back(t + 2 + DB);
        lq.push_back(acc);
      end
      t += segs[i].len;
    end
    total = t;
    for (int i = 0; i < tq.size(); i++) begin
      int nxt;
      int ticks;
      nxt = (i + 1 < tq.size()) ? tq[i+1] : 32'h7fff_ffff;
      put(total, tq[i], 0, lq[i] ? "K" : "k");
      if (lq[i]) begin
        if (!busy_m) begin
          put(total, tq[i] + 1, 3, "B");
          busy_m = 1'b1;
        end
      end else begin
        ticks = (tq[i] - tq[i-1] - 1) / TD;
        if (ticks > (1 << CW) - 1) ticks = (1 << CW) - 1;
        put(total, tq[i] + 1, 1, (ticks < DM) ? "D" : "H");
        if (nxt > tq[i] + TD * LG) put(total, tq[i] + 1 + TD * LG, 1, "L");
        if (nxt > tq[i] + TD * WG) begin
          put(total, tq[i] + 1 + TD * WG, 2, "W");
          put(total, tq[i] + 1 + TD * WG, 3, "b");
          busy_m = 1'b0;
        end
      end
    end
    foreach (exp_q[i]) s = {s, $sformatf("%c%0d ", exp_q[i].k, exp_q[i].cyc)};
    return s;
  endfunction

  task automatic test_reset();
    int bad = 0;
    do_reset();
    checks++;
    if ({sym_code, sym_valid, word_end, key_db, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000", {sym_code, sym_valid, word_end, key_db, busy});
    end
    repeat (10) begin
      @(negedge clk);
      if ({sym_code, sym_valid, word_end, key_db, busy} !== 6'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle_quiet: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_single_dot();
    string e;
    do_reset();
    segs.delete();
    add_seg(1, 5);
    add_seg(0, 60);
    play();
    e = predict();
    checks++;
    if (obs_all != e) begin
      errors++;
      $display("FAIL single_dot_model: got '%s' want '%s'", obs_all, e);
    end
    checks++;
    if (obs_all != "K5 B6 k10 D11 L23 W39 b39 ") begin
      errors++;
      $display("FAIL single_dot_timing: got '%s' want 'K5 B6 k10 D11 L23 W39 b39 '", obs_all);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL single_dot_strobe_rules: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_dash_thresholds();
    string e;
    do_reset();
    segs.delete();
    add_seg(1, 21); add_seg(0, 40);   // 10 ticks
    add_seg(1, 9);  add_seg(0, 40);   // exactly DOT_MAX ticks
    add_seg(1, 7);  add_seg(0, 40);   // DOT_MAX-1 ticks
    play();
    e = predict();
    checks++;
    if (obs_all != e) begin
      errors++;
      $display("FAIL dash_threshold_model: got '%s' want '%s'", obs_all, e);
    end
    checks++;
    if (obs_sym != "3 2 3 2 1 2 ") begin
      errors++;
      $display("FAIL dash_threshold_codes: got '%s' want '3 2 3 2 1 2 '", obs_sym);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL dash_threshold_strobe_rules: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_letter_a();
    string e;
    do_reset();
    segs.delete();
    add_seg(1, 3);  add_seg(0, 7);    // dot, 3-tick gap
    add_seg(1, 11); add_seg(0, 17);   // dash, 8-tick gap
    add_seg(1, 30);
    play();
    e = predict();
    checks++;
    if (obs_all != e) begin
      errors++;
      $display("FAIL letter_a_model: got '%s' want '%s'", obs_all, e);
    end
    checks++;
    if (obs_sym != "1 3 2 ") begin
      errors++;
      $display("FAIL letter_a_codes: got '%s' want '1 3 2 '", obs_sym);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL letter_a_strobe_rules: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_glitch();
    string e;
    do_reset();
    segs.delete();
    add_seg(1, 5); add_seg(0, 8);
    add_seg(1, 1); add_seg(0, 6);
    add_seg(1, 1); add_seg(0, 60);
    play();
    e = predict();
    checks++;
    if (obs_all != e) begin
      errors++;
      $display("FAIL glitch_model: got '%s' want '%s'", obs_all, e);
    end
    checks++;
    if (obs_all != "K5 B6 k10 D11 L23 W39 b39 ") begin
      errors++;
      $display("FAIL glitch_filtered: got '%s' want 'K5 B6 k10 D11 L23 W39 b39 '", obs_all);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL glitch_strobe_rules: got %0d violations want 0", viol);
    end
    // Clean step from idle: latency key_in -> key_db.
    segs.delete();
    add_seg(1, 12);
    add_seg(0, 50);
    play();
    e = predict();
    checks++;
    if (first_k !== 2 + DB) begin
      errors++;
      $display("FAIL debounce_latency: got %0d want %0d", first_k, 2 + DB);
    end
    checks++;
    if (obs_all != e) begin
      errors++;
      $display("FAIL clean_step_model: got '%s' want '%s'", obs_all, e);
    end
  endtask

  task automatic test_rise_at_letter_gap();
    string e;
    do_reset();
    segs.delete();
    add_seg(1, 5); add_seg(0, 12);    // key_db rises on the letter-gap cycle
    add_seg(1, 9); add_seg(0, 40);
    play();
    e = predict();
    checks++;
    if (obs_all != e) begin
      errors++;
      $display("FAIL rise_wins_model: got '%s' want '%s'", obs_all, e);
    end
    checks++;
    if (obs_all != "K5 B6 k10 D11 K22 k31 H32 L44 W60 b60 ") begin
      errors++;
      $display("FAIL rise_wins_timing: got '%s' want 'K5 B6 k10 D11 K22 k31 H32 L44 W60 b60 '", obs_all);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL rise_wins_strobe_rules: got %0d violations want 0", viol);
    end
    // One cycle later the letter-end is already out.
    do_reset();
    segs.delete();
    add_seg(1, 5); add_seg(0, 13);
    add_seg(1, 9); add_seg(0, 40);
    play();
    e = predict();
    checks++;
    if (obs_all != e) begin
      errors++;
      $display("FAIL rise_late_model: got '%s' want '%s'", obs_all, e);
    end
    checks++;
    if (obs_sym != "1 2 3 2 ") begin
      errors++;
      $display("FAIL rise_late_codes: got '%s' want '1 2 3 2 '", obs_sym);
    end
  endtask

  task automatic test_reset_mid_mark();
    string e;
    int    strobes = 0;
    do_reset();
    key_in = 1'b1;
    repeat (13) begin
      @(negedge clk);
      if (sym_valid === 1'b1 || word_end === 1'b1) strobes++;
    end
    checks++;
    if (busy !== 1'b1 || strobes != 0) begin
      errors++;
      $display("FAIL mid_mark_before_reset: got busy=%b strobes=%0d want busy=1 strobes=0", busy, strobes);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sym_code, sym_valid, word_end, key_db, busy} !== 6'b0) begin
      errors++;
      $display("FAIL mid_mark_reset_outputs: got %b want 000000", {sym_code, sym_valid, word_end, key_db, busy});
    end
    rst = 1'b0;
    segs.delete();
    add_seg(1, 7);                    // 3 ticks after the fresh rise: dot
    add_seg(0, 40);
    play();
    e = predict();
    checks++;
    if (obs_all != e) begin
      errors++;
      $display("FAIL mid_mark_restart_model: got '%s' want '%s'", obs_all, e);
    end
    checks++;
    if (obs_sym != "1 2 ") begin
      errors++;
      $display("FAIL mid_mark_restart_codes: got '%s' want '1 2 '", obs_sym);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL mid_mark_strobe_rules: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_random();
    string e;
    for (int run = 0; run < 6; run++) begin
      bit lvl = 1'b1;
      do_reset();
      segs.delete();
      for (int k = 0; k < 8; k++) begin
        int len;
        int a;
        len = lvl ? $urandom_range(24, 3) : $urandom_range(36, 3);
        if (len >= 7 && $urandom_range(3, 0) == 0) begin
          a = $urandom_range(len - 4, 3);
          add_seg(lvl, a);
          add_seg(!lvl, 1);
          add_seg(lvl, len - a - 1);
        end else begin
          add_seg(lvl, len);
        end
        lvl = !lvl;
      end
      add_seg(0, 40);
      play();
      e = predict();
      checks++;
      if (obs_all != e) begin
        errors++;
        $display("FAIL random_run%0d: got '%s' want '%s'", run, obs_all, e);
      end
      checks++;
      if (viol != 0) begin
        errors++;
        $display("FAIL random_run%0d_strobe_rules: got %0d violations want 0", run, viol);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_dot();
    test_dash_thresholds();
    test_letter_a();
    test_glitch();
    test_rise_at_letter_gap();
    test_reset_mid_mark();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
